key_press_gen: RTL and testbench
================================

Name: key_press_gen

Overview:
- Generates an active-low push-button waveform on a single `key` line. It is the driving end of the key/debounce interface.
- Models a mechanical press: an optional contact-bounce burst, a stable-low hold, an optional release bounce, then a stable-high recovery gap.
- Used for board self-test and for bench stimulus of the debounce/press-count path.
- Keeps its own modulo-10 press count so the debounced count on the receiving side can be cross-checked.

Parameters:
- CNT_W, 24, width of the hold/gap/segment cycle counters.
- BOUNCE_EDGES, 4, number of low/high glitch pairs in each bounce burst; must be ≥1.
- BOUNCE_CYC, 1000, cycles per bounce segment; must be ≥1 and < 2^CNT_W.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous reset, active-high.
- start, input, 1, request one press; sampled only in IDLE.
- hold_cyc, input, CNT_W, stable-low hold length in cycles; latched on start; 0 is treated as 1.
- gap_cyc, input, CNT_W, stable-high recovery length in cycles; latched on start; 0 skips GAP.
- bounce_en, input, 1, enables both bounce bursts; latched on start.
- key, output, 1, active-low key line, registered; idle level is 1.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse when a press sequence completes.
- press_cnt, output, 4, completed-hold count, modulo 10.

Behaviour:
- Reset (synchronous, active-high). On the next clk edge with rst=1:
  - state=IDLE, key=1, busy=0, done=0, press_cnt=0, all counters=0.
  - Reset mid-sequence aborts immediately; no done pulse is produced.
- Registered outputs: key, busy, done and press_cnt are all registered.
- States: IDLE, B_IN, HOLD, B_OUT, GAP.
- IDLE:
  - key=1.
  - start=1 latches hold_cyc, gap_cyc and bounce_en.
  - Next state is B_IN if bounce_en, else HOLD.
  - key goes low on the edge that accepts start, so key=0 and busy=1 in the following cycle.
- B_IN:
  - 2*BOUNCE_EDGES segments of BOUNCE_CYC cycles each, alternating key = 0,1,0,1,…; the first segment is low.
  - Then HOLD.
- HOLD:
  - key=0 for max(hold_cyc,1) cycles.
  - On the last HOLD cycle press_cnt increments: 9→0 wrap, otherwise +1.
  - Next state is B_OUT if bounce_en, else GAP.
- B_OUT:
  - 2*BOUNCE_EDGES segments of BOUNCE_CYC cycles each, alternating key = 1,0,1,0,…; the first segment is high.
  - Then GAP.
- GAP:
  - key=1 for gap_cyc cycles.
  - When gap_cyc=0 the state passes straight to IDLE with no GAP cycle.
- Completion:
  - done=1 for exactly one cycle: the first cycle back in IDLE, in which busy=0.
  - start asserted while done=1 is accepted; back-to-back presses are allowed.
- start while busy is ignored: no queuing, no error.
- Input stability: changes on hold_cyc, gap_cyc or bounce_en while busy have no effect on the sequence in progress.
- Total key-low-or-bouncing span with bounce enabled: 2*BOUNCE_EDGES*BOUNCE_CYC + max(hold_cyc,1) + 2*BOUNCE_EDGES*BOUNCE_CYC cycles.
- Counters:
  - Segment/hold/gap counter is CNT_W bits, down-counting, reloaded on each state/segment entry.
  - Bounce segment index is $clog2(2*BOUNCE_EDGES)+1 bits.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, B_IN, HOLD, B_OUT, GAP);
  - the PRESS_MOD=10 constant, shared with the press-counting receiver.
- One natural sub-module, key_seg_timer: a loadable CNT_W down-counter with a zero flag, reused for segment, hold and gap timing.
- The FSM and press_cnt stay in the top module.

Test Plan:
All scenarios use BOUNCE_EDGES=2 and BOUNCE_CYC=4.
- Reset then idle 20 cycles -> key=1, busy=0, done=0, press_cnt=0 throughout.
- start with hold_cyc=10, gap_cyc=5, bounce_en=0 -> key=0 for exactly 10 cycles starting the cycle after start, then key=1; done pulses once 5 cycles later; press_cnt=1.
- Same press with bounce_en=1 -> key shows 0,1,0,1 segments of 4 cycles each, 10 low cycles, then 1,0,1,0 segments of 4 cycles, 5 high; busy lasts 16+10+16+5=47 cycles; done pulses once.
- 10 back-to-back presses, each start issued on the done cycle, hold_cyc=0, gap_cyc=0 -> each hold lasts 1 cycle; press_cnt runs 1..9 then 0; no idle gap between sequences other than the done cycle.
- start pulsed mid-HOLD, and hold_cyc changed to 3 mid-HOLD -> no restart; the original 10-cycle hold completes unchanged.
- rst asserted during B_OUT -> next cycle key=1, busy=0, press_cnt=0, and done never pulses.

Source files
------------

// File: rtl/key_press_gen_pkg.sv
// key_press_gen_pkg
//   Shared definitions for the key press generator and the receiving
//   press counter: FSM state encoding, the press-count modulus and a
//   helper that advances a modulo-PRESS_MOD count.
package key_press_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B_IN,
        ST_HOLD,
        ST_B_OUT,
        ST_GAP
    } kp_state_e;

    localparam int unsigned PRESS_MOD = 10;

    function automatic logic [3:0] next_press(input logic [3:0] cnt);
        return (cnt == 4'(PRESS_MOD - 1)) ? 4'd0 : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/key_seg_timer.sv
// key_seg_timer
//   Loadable down-counter used for bounce segments, hold and gap timing.
//   Loading N-1 makes zero assert on the N-th cycle after the load edge,
//   i.e. zero marks the last cycle of an N-cycle interval.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (count -> 0)
//   load     - reload the counter with load_val
//   load_val - reload value (interval length minus one)
//   zero     - count has reached zero
module key_seg_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/key_press_gen.sv
// key_press_gen
//   Drives an active-low push-button waveform: optional press bounce,
//   stable-low hold, optional release bounce, stable-high gap. Keeps a
//   modulo-10 count of completed holds for cross-checking a debouncer.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - request one press (accepted only in IDLE)
//   hold_cyc   - low hold length in cycles (0 treated as 1), latched on start
//   gap_cyc    - high recovery length in cycles (0 skips GAP), latched on start
//   bounce_en  - enable bounce bursts, latched on start
//   key        - registered active-low key line, idles high
//   busy       - registered, high while a press sequence is in progress
//   done       - registered one-cycle pulse on the first cycle back in IDLE
//   press_cnt  - registered completed-hold count, modulo 10
module key_press_gen
    import key_press_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned BOUNCE_EDGES = 4,
    parameter int unsigned BOUNCE_CYC   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] hold_cyc,
    input  logic [CNT_W-1:0] gap_cyc,
    input  logic             bounce_en,
    output logic             key,
    output logic             busy,
    output logic             done,
    output logic [3:0]       press_cnt
);

    localparam int unsigned      SEG_W    = $clog2(2 * BOUNCE_EDGES) + 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(2 * BOUNCE_EDGES - 1);
    localparam logic [CNT_W-1:0] SEG_LOAD = CNT_W'(BOUNCE_CYC - 1);

    kp_state_e        state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             ben_q, ben_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    key_seg_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        ben_d    = ben_q;
        cnt_d    = cnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hold_d   = hold_cyc;
                    gap_d    = gap_cyc;
                    ben_d    = bounce_en;
                    seg_d    = '0;
                    tmr_load = 1'b1;
                    if (bounce_en) begin
                        state_d = ST_B_IN;
                        tmr_val = SEG_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        tmr_val = (hold_cyc == '0) ? '0 : hold_cyc - CNT_W'(1);
                    end
                end
            end
            ST_B_IN: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (seg_q == SEG_LAST) begin
                        state_d = ST_HOLD;
                        tmr_val = (hold_q == '0) ? '0 : hold_q - CNT_W'(1);
                    end else begin
                        seg_d   = seg_q + SEG_W'(1);
                        tmr_val = SEG_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    cnt_d = next_press(cnt_q);
                    if (ben_q) begin
                        state_d  = ST_B_OUT;
                        seg_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = SEG_LOAD;
                    end else if (gap_q != '0) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_q - CNT_W'(1);
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_B_OUT: begin
                if (tmr_zero) begin
                    if (seg_q != SEG_LAST) begin
                        seg_d    = seg_q + SEG_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = SEG_LOAD;
                    end else if (gap_q != '0) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_q - CNT_W'(1);
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        // Press bounce starts low (even segments low); release bounce
        // starts high (even segments high).
        unique case (state_d)
            ST_B_IN:  key_d = seg_d[0];
            ST_HOLD:  key_d = 1'b0;
            ST_B_OUT: key_d = ~seg_d[0];
            default:  key_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            ben_q   <= 1'b0;
            key_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            ben_q   <= ben_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key       = key_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign press_cnt = cnt_q;

endmodule

// File: tb/tb_key_press_gen.sv
module tb_key_press_gen;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BE    = 2;
    localparam int unsigned BC    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] hold_cyc;
    logic [CNT_W-1:0] gap_cyc;
    logic             bounce_en;
    logic             key;
    logic             busy;
    logic             done;
    logic [3:0]       press_cnt;

    always #5 clk = ~clk;

    key_press_gen #(
        .CNT_W        (CNT_W),
        .BOUNCE_EDGES (BE),
        .BOUNCE_CYC   (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold_cyc  (hold_cyc),
        .gap_cyc   (gap_cyc),
        .bounce_en (bounce_en),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .press_cnt (press_cnt)
    );

    typedef struct packed {
        logic       key;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    function automatic obs_t mk(input logic k, input logic b, input logic d, input int c);
        obs_t r;
        r.key  = k;
        r.busy = b;
        r.done = d;
        r.cnt  = 4'(c);
        return r;
    endfunction

    // Expected per-cycle waveform of one press, starting the cycle after
    // the start edge and ending with the done cycle.
    task automatic push_press(input int h, input int g, input logic b);
        int hl;
        hl = (h == 0) ? 1 : h;
        if (b) begin
            for (int s = 0; s < 2 * BE; s++)
                for (int c = 0; c < BC; c++)
                    exp_q.push_back(mk((s % 2) == 1, 1'b1, 1'b0, exp_cnt));
        end
        for (int i = 0; i < hl; i++)
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, exp_cnt));
        exp_cnt = (exp_cnt + 1) % 10;
        if (b) begin
            for (int s = 0; s < 2 * BE; s++)
                for (int c = 0; c < BC; c++)
                    exp_q.push_back(mk((s % 2) == 0, 1'b1, 1'b0, exp_cnt));
        end
        for (int i = 0; i < g; i++)
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, exp_cnt));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, exp_cnt));
    endtask

    // Issues start at the current negedge (DUT must be idle) and checks
    // every cycle through the done cycle; returns at the done-cycle negedge.
    // disturb_at >= 0 pulses start and alters the inputs at that cycle.
    task automatic drive_press(input string name, input int h, input int g,
                               input logic b, input int disturb_at);
        int   n;
        obs_t e;
        obs_t o;
        hold_cyc  = CNT_W'(h);
        gap_cyc   = CNT_W'(g);
        bounce_en = b;
        start     = 1'b1;
        push_press(h, g, b);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == disturb_at) begin
                start     = 1'b1;
                hold_cyc  = CNT_W'(3);
                gap_cyc   = '0;
                bounce_en = ~b;
            end
            e = exp_q.pop_front();
            o = {key, busy, done, press_cnt};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s cyc=%0d got key=%b busy=%b done=%b cnt=%0d exp key=%b busy=%b done=%b cnt=%0d",
                         name, i, o.key, o.busy, o.done, o.cnt, e.key, e.busy, e.done, e.cnt);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        rst = 1'b1;
        start = 1'b0;
        hold_cyc = '0;
        gap_cyc = '0;
        bounce_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = {key, busy, done, press_cnt};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got key=%b busy=%b done=%b cnt=%0d exp key=%b busy=%b done=%b cnt=%0d",
                         i, o.key, o.busy, o.done, o.cnt, e.key, e.busy, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_no_bounce();
        drive_press("no_bounce", 10, 5, 1'b0, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        drive_press("bounce", 10, 5, 1'b1, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        for (int p = 0; p < 10; p++) drive_press("back_to_back", 0, 0, 1'b0, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ignore_mid_hold();
        drive_press("mid_hold_ignore", 10, 2, 1'b0, 4);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        obs_t e;
        hold_cyc  = CNT_W'(10);
        gap_cyc   = CNT_W'(5);
        bounce_en = 1'b1;
        start     = 1'b1;
        push_press(10, 5, 1'b1);
        // Walk through press bounce, hold and into the release bounce.
        for (int i = 0; i < 16 + 10 + 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            o = {key, busy, done, press_cnt};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got key=%b busy=%b done=%b cnt=%0d exp key=%b busy=%b done=%b cnt=%0d",
                         i, o.key, o.busy, o.done, o.cnt, e.key, e.busy, e.done, e.cnt);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b0;
        e = exp_q.pop_front();
        o = {key, busy, done, press_cnt};
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid_abort got key=%b busy=%b done=%b cnt=%0d exp key=%b busy=%b done=%b cnt=%0d",
                     o.key, o.busy, o.done, o.cnt, e.key, e.busy, e.done, e.cnt);
        end
        for (int i = 0; i < 60; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = {key, busy, done, press_cnt};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d got key=%b busy=%b done=%b cnt=%0d exp key=%b busy=%b done=%b cnt=%0d",
                         i, o.key, o.busy, o.done, o.cnt, e.key, e.busy, e.done, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_bounce();
        test_bounce();
        test_back_to_back();
        test_ignore_mid_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
